sobel_peak_detect: RTL and testbench

Downstream stage of the Sobel magnitude block. Consumes the 8-bit normalised gradient-magnitude stream in raster order and buffers two image lines to form a 3x3 window. For every interior pixel it flags whether the pixel is a thresholded local maximum, which yields candidate particle centres for the detector back end. It emits the row/column coordinate and magnitude of each candidate plus an end-of-frame pulse.

---
 rtl/sobel_peak_detect.sv | 142 ++++++++++++++
 tb/tb_sobel_peak_detect.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_peak_detect.sv
// Thresholded 3x3 local-maximum detector on a raster magnitude stream.
// Two line buffers feed a sliding window; one registered result per interior pixel.
module sobel_peak_detect #(
  parameter int          IMGW   = 512,
  parameter int          IMGH   = 1024,
  parameter int          COLW   = 9,
  parameter int          ROWW   = 10,
  parameter logic [7:0]  THRESH = 8'd32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            magValid,
  input  logic [7:0]      mag,
  output logic            outValid,
  output logic            peakFlag,
  output logic [7:0]      peakMag,
  output logic [COLW-1:0] peakCol,
  output logic [ROWW-1:0] peakRow,
  output logic            frameDone
);

  localparam logic [COLW-1:0] COL_LAST = COLW'(IMGW - 1);
  localparam logic [ROWW-1:0] ROW_LAST = ROWW'(IMGH - 1);
  localparam logic [COLW-1:0] COL_MIN  = COLW'(2);
  localparam logic [ROWW-1:0] ROW_MIN  = ROWW'(2);

  logic [7:0]      line_a_q [IMGW];
  logic [7:0]      line_b_q [IMGW];

  logic [COLW-1:0] col_q, col_d;
  logic [ROWW-1:0] row_q, row_d;
  // Window columns: [0] holds column c-1, [1] holds column c-2; column c is the incoming pixel.
  logic [1:0][7:0] top_q, top_d, mid_q, mid_d, bot_q, bot_d;

  logic            out_valid_q, out_valid_d;
  logic            peak_flag_q, peak_flag_d;
  logic [7:0]      peak_mag_q, peak_mag_d;
  logic [COLW-1:0] peak_col_q, peak_col_d;
  logic [ROWW-1:0] peak_row_q, peak_row_d;
  logic            frame_done_q, frame_done_d;

  logic [7:0]      top_in_s, mid_in_s, centre_s;
  logic            peak_s, emit_s, last_px_s;

  // Counter advance and window shift on each accepted pixel.
  always_comb begin
    col_d    = col_q;
    row_d    = row_q;
    top_in_s = line_b_q[col_q];
    mid_in_s = line_a_q[col_q];
    top_d    = top_q;
    mid_d    = mid_q;
    bot_d    = bot_q;
    if (magValid) begin
      top_d = {top_q[0], top_in_s};
      mid_d = {mid_q[0], mid_in_s};
      bot_d = {bot_q[0], mag};
      if (col_q == COL_LAST) begin
        col_d = '0;
        if (row_q == ROW_LAST) begin
          row_d = '0;
        end else begin
          row_d = row_q + ROWW'(1);
        end
      end else begin
        col_d = col_q + COLW'(1);
      end
    end else begin
      col_d = col_q;
      row_d = row_q;
    end
  end

  // Peak rule: strict against raster-earlier neighbours so a plateau marks only its first pixel.
  always_comb begin
    centre_s  = mid_q[0];
    peak_s    = (centre_s >= THRESH)
              && (centre_s >  top_q[1]) && (centre_s >  top_q[0]) && (centre_s >  top_in_s)
              && (centre_s >  mid_q[1]) && (centre_s >= mid_in_s)
              && (centre_s >= bot_q[1]) && (centre_s >= bot_q[0]) && (centre_s >= mag);
    emit_s    = magValid && (row_q >= ROW_MIN) && (col_q >= COL_MIN);
    last_px_s = magValid && (row_q == ROW_LAST) && (col_q == COL_LAST);
    out_valid_d  = emit_s;
    frame_done_d = last_px_s;
    if (emit_s) begin
      peak_flag_d = peak_s;
      peak_mag_d  = centre_s;
      peak_col_d  = col_q - COLW'(1);
      peak_row_d  = row_q - ROWW'(1);
    end else begin
      peak_flag_d = peak_flag_q;
      peak_mag_d  = peak_mag_q;
      peak_col_d  = peak_col_q;
      peak_row_d  = peak_row_q;
    end
  end

  // State and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      col_q        <= '0;
      row_q        <= '0;
      top_q        <= '0;
      mid_q        <= '0;
      bot_q        <= '0;
      out_valid_q  <= 1'b0;
      peak_flag_q  <= 1'b0;
      peak_mag_q   <= 8'd0;
      peak_col_q   <= '0;
      peak_row_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      top_q        <= top_d;
      mid_q        <= mid_d;
      bot_q        <= bot_d;
      out_valid_q  <= out_valid_d;
      peak_flag_q  <= peak_flag_d;
      peak_mag_q   <= peak_mag_d;
      peak_col_q   <= peak_col_d;
      peak_row_q   <= peak_row_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Line buffers are not reset; rows 0 and 1 refill them before any result is emitted.
  always_ff @(posedge clk) begin
    if (magValid && !reset) begin
      line_b_q[col_q] <= line_a_q[col_q];
      line_a_q[col_q] <= mag;
    end
  end

  assign outValid  = out_valid_q;
  assign peakFlag  = peak_flag_q;
  assign peakMag   = peak_mag_q;
  assign peakCol   = peak_col_q;
  assign peakRow   = peak_row_q;
  assign frameDone = frame_done_q;

endmodule

// File: tb/tb_sobel_peak_detect.sv
// Scoreboard bench for sobel_peak_detect on an 8x6 image: the driver pushes expected
// results computed from a whole-image reference model, a monitor pops and compares.
module tb_sobel_peak_detect;

  localparam int W = 8;
  localparam int H = 6;
  localparam int THR = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic       magValid;
  logic [7:0] mag;
  logic       outValid, peakFlag, frameDone;
  logic [7:0] peakMag;
  logic [2:0] peakCol;
  logic [2:0] peakRow;

  sobel_peak_detect #(.IMGW(W), .IMGH(H), .COLW(3), .ROWW(3), .THRESH(8'd32)) dut (
    .clk(clk), .reset(reset), .magValid(magValid), .mag(mag),
    .outValid(outValid), .peakFlag(peakFlag), .peakMag(peakMag),
    .peakCol(peakCol), .peakRow(peakRow), .frameDone(frameDone)
  );

  always #5 clk = ~clk;

  typedef struct {int r; int c; int m; bit f; int cyc;} exp_t;
  exp_t q[$];
  int   dq[$];
  int   img [H][W];
  int   cyc = 0;
  int   total = 0, bad = 0;
  int   strobes_seen = 0, peaks_seen = 0, done_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Reference: thresholded local max, strict against raster-earlier neighbours.
  function automatic bit ref_peak(input int r, input int c);
    int v = img[r][c];
    if (v < THR) return 1'b0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        bit earlier;
        int n;
        if (dr == 0 && dc == 0) continue;
        n = img[r+dr][c+dc];
        earlier = (dr < 0) || (dr == 0 && dc < 0);
        if (earlier && v <= n) return 1'b0;
        if (!earlier && v < n) return 1'b0;
      end
    end
    return 1'b1;
  endfunction

  function automatic int ref_peak_count();
    int n = 0;
    for (int r = 1; r <= H - 2; r++)
      for (int c = 1; c <= W - 2; c++)
        if (ref_peak(r, c)) n++;
    return n;
  endfunction

  task automatic clear_img();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      magValid = 1'b0;
      mag = 8'($urandom);
    end
  endtask

  task automatic drive_px(input int r, input int c);
    exp_t e;
    @(negedge clk);
    magValid = 1'b1;
    mag = 8'(img[r][c]);
    if (r >= 2 && c >= 2) begin
      e.r = r - 1; e.c = c - 1; e.m = img[r-1][c-1];
      e.f = ref_peak(r - 1, c - 1); e.cyc = cyc + 1;
      q.push_back(e);
    end
    if (r == H - 1 && c == W - 1) dq.push_back(cyc + 1);
  endtask

  task automatic do_reset(input bit mv);
    @(negedge clk);
    reset = 1'b1;
    magValid = mv;
    mag = 8'd77;
    q.delete();
    dq.delete();
    @(negedge clk);
    reset = 1'b0;
    magValid = 1'b0;
  endtask

  task automatic run_frame(input string name, input int gap_pct);
    int exp_peaks = ref_peak_count();
    strobes_seen = 0; peaks_seen = 0; done_seen = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (gap_pct > 0 && (c == 0 || $urandom_range(0, 99) < gap_pct))
          idle($urandom_range(1, 3));
        drive_px(r, c);
      end
    end
    idle(gap_pct > 0 ? 5 : 3);
    chk({name, "_strobes"}, strobes_seen, (H - 2) * (W - 2));
    chk({name, "_peaks"}, peaks_seen, exp_peaks);
    chk({name, "_frame_done"}, done_seen, 1);
  endtask

  // Monitor: pops expected results and frame-end pulses as the DUT presents them.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (outValid === 1'b1) begin
        strobes_seen++;
        if (peakFlag) peaks_seen++;
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL strobe_unexpected: got strobe r=%0d c=%0d at edge %0d, required none",
                   peakRow, peakCol, cyc);
        end else begin
          e = q.pop_front();
          if (peakRow !== 3'(e.r) || peakCol !== 3'(e.c) || peakMag !== 8'(e.m) ||
              peakFlag !== e.f || cyc != e.cyc) begin
            bad++;
            $display("FAIL strobe: got r=%0d c=%0d m=%0d f=%0d edge=%0d, required r=%0d c=%0d m=%0d f=%0d edge=%0d",
                     peakRow, peakCol, peakMag, peakFlag, cyc, e.r, e.c, e.m, e.f, e.cyc);
          end
        end
      end else if (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        total++; bad++;
        $display("FAIL strobe_missing: got no strobe at edge %0d, required r=%0d c=%0d", cyc, e.r, e.c);
      end
      if (frameDone === 1'b1) begin
        done_seen++;
        total++;
        if (dq.size() == 0 || dq[0] != cyc) begin
          bad++;
          $display("FAIL frame_done: got pulse at edge %0d, required %0d", cyc,
                   dq.size() > 0 ? dq[0] : -1);
        end
        if (dq.size() > 0 && dq[0] == cyc) void'(dq.pop_front());
      end else if (dq.size() > 0 && dq[0] <= cyc) begin
        total++; bad++;
        $display("FAIL frame_done_missing: got none at edge %0d, required at %0d", cyc, dq[0]);
        void'(dq.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b1; magValid = 1'b0; mag = 8'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_outValid", int'(outValid), 0);
    chk("rst_peakFlag", int'(peakFlag), 0);
    chk("rst_peakMag", int'(peakMag), 0);
    chk("rst_peakCol", int'(peakCol), 0);
    chk("rst_peakRow", int'(peakRow), 0);
    chk("rst_frameDone", int'(frameDone), 0);
    strobes_seen = 0; done_seen = 0;
    idle(20);
    chk("idle_strobes", strobes_seen, 0);
    chk("idle_frame_done", done_seen, 0);

    clear_img();
    run_frame("zero", 0);
    img[3][4] = 200;
    run_frame("spike200", 0);
    img[3][4] = 31;
    run_frame("spike31", 0);
    img[3][4] = 32;
    run_frame("spike32", 0);
    clear_img();
    img[2][3] = 100; img[2][4] = 100;
    run_frame("plateau", 0);

    clear_img();
    img[3][4] = 200;
    run_frame("spike_gaps", 35);

    for (int k = 0; k < 3; k++) begin
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++)
          img[r][c] = $urandom_range(0, 48);
      run_frame("random", 30);
    end

    clear_img();
    img[3][4] = 200;
    for (int i = 0; i < 20; i++) drive_px(i / W, i % W);
    do_reset(1'b1);
    chk("abort_outValid", int'(outValid), 0);
    chk("abort_frameDone", int'(frameDone), 0);
    run_frame("after_abort", 0);
    chk("after_abort_peak_count", peaks_seen, 1);

    idle(3);
    chk("queue_drained", q.size(), 0);
    chk("done_queue_drained", dq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
